// File: rtl/ped_signal_ctrl.sv
// Pedestrian signal controller slaved to a vehicle light: grants WALK on red onset
// when a request is latched, then flashes DON'T-WALK before returning to IDLE.
module ped_signal_ctrl #(
  parameter int WALK_CYCLES  = 20,
  parameter int FLASH_CYCLES = 10,
  parameter int FLASH_HALF   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] light,
  input  logic       ped_btn,
  output logic       walk,
  output logic       dont_walk,
  output logic [7:0] countdown,
  output logic       req_pending,
  output logic       fault
);

  typedef enum logic [1:0] {IDLE, WALK, FLASH, FAULT} state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [7:0] WALK_LEN  = 8'(WALK_CYCLES);
  localparam logic [7:0] FLASH_LEN = 8'(FLASH_CYCLES);
  localparam logic [7:0] HALF_LEN  = 8'(FLASH_HALF);

  state_t     state;
  logic [2:0] prev_light;
  logic [7:0] flash_cnt;   // cycles already shown in the current flash half-period
  logic       legal;
  logic       onset;

  assign legal = (light == RED) || (light == YEL) || (light == GRN);
  assign onset = (light == RED) && (prev_light != RED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      prev_light  <= RED;
      flash_cnt   <= 8'd0;
      walk        <= 1'b0;
      dont_walk   <= 1'b1;
      countdown   <= 8'd0;
      req_pending <= 1'b0;
      fault       <= 1'b0;
    end else begin
      prev_light <= light;
      if (!legal || state == FAULT) begin
        // FAULT is absorbing; only reset leaves it and the button is ignored
        state     <= FAULT;
        walk      <= 1'b0;
        dont_walk <= 1'b1;
        countdown <= 8'd0;
        flash_cnt <= 8'd0;
        fault     <= 1'b1;
      end else begin
        if (ped_btn) req_pending <= 1'b1;
        case (state)
          IDLE: begin
            if (onset && req_pending) begin
              state       <= WALK;
              walk        <= 1'b1;
              dont_walk   <= 1'b0;
              countdown   <= WALK_LEN;
              req_pending <= 1'b0;
            end
          end
          WALK: begin
            if (light != RED) begin
              state     <= IDLE;
              walk      <= 1'b0;
              dont_walk <= 1'b1;
              countdown <= 8'd0;
            end else if (countdown <= 8'd1) begin
              state     <= FLASH;
              walk      <= 1'b0;
              dont_walk <= 1'b1;
              countdown <= FLASH_LEN;
              flash_cnt <= 8'd1;
            end else begin
              countdown <= countdown - 8'd1;
            end
          end
          FLASH: begin
            if (light != RED || countdown <= 8'd1) begin
              state     <= IDLE;
              walk      <= 1'b0;
              dont_walk <= 1'b1;
              countdown <= 8'd0;
              flash_cnt <= 8'd0;
            end else begin
              countdown <= countdown - 8'd1;
              if (flash_cnt >= HALF_LEN) begin
                flash_cnt <= 8'd1;
                dont_walk <= ~dont_walk;
              end else begin
                flash_cnt <= flash_cnt + 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Directed vector bench for ped_signal_ctrl with default parameters (20/10/2).
module tb_ped_signal_ctrl;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] light = R;
  logic       ped_btn = 1'b0;
  logic       walk, dont_walk, req_pending, fault;
  logic [7:0] countdown;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  ped_signal_ctrl dut (
    .clk(clk), .reset(reset), .light(light), .ped_btn(ped_btn),
    .walk(walk), .dont_walk(dont_walk), .countdown(countdown),
    .req_pending(req_pending), .fault(fault)
  );

  always #5 clk = ~clk;

  // Inputs applied for one edge, then the outputs expected just after that edge.
  typedef struct {
    logic [2:0] light;
    logic       btn;
    logic       rst;
    logic       w;
    logic       dw;
    logic [7:0] cd;
    logic       req;
    logic       flt;
    string      tag;
  } vec_t;

  vec_t vq[$];

  function automatic void v(input logic [2:0] l, input logic b, input logic r,
                            input logic w, input logic dw, input int cd,
                            input logic req, input logic flt, input string tag);
    vec_t e;
    e.light = l; e.btn = b; e.rst = r; e.w = w; e.dw = dw;
    e.cd = 8'(cd); e.req = req; e.flt = flt; e.tag = tag;
    vq.push_back(e);
  endfunction

  // walk and dont_walk must never be lit together
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (walk && dont_walk) begin
        failures++;
        $display("FAIL lamp_excl t=%0t walk=%0b dont_walk=%0b required not both 1", $time, walk, dont_walk);
      end
    end
  end

  initial begin
    logic [11:0] got, exp;

    // reset and basic cycle
    v(R,0,1, 0,1,0, 0,0, "reset");
    v(G,0,0, 0,1,0, 0,0, "idle_green");
    v(G,1,0, 0,1,0, 1,0, "btn_latch");
    v(G,0,0, 0,1,0, 1,0, "req_hold");
    v(R,0,0, 1,0,20, 0,0, "walk_entry");
    for (int k = 19; k >= 1; k--) v(R,0,0, 1,0,k, 0,0, "walk_count");
    for (int i = 0; i < 10; i++) v(R,0,0, 0,((i/2)%2)==0,10-i, 0,0, "flash");
    v(R,0,0, 0,1,0, 0,0, "idle_after_flash");
    v(R,0,0, 0,1,0, 0,0, "idle_red_steady");

    // steady red: request waits for the next onset
    v(R,1,0, 0,1,0, 1,0, "steady_press");
    v(R,0,0, 0,1,0, 1,0, "steady_no_walk");
    v(R,0,0, 0,1,0, 1,0, "steady_no_walk2");
    v(Y,0,0, 0,1,0, 1,0, "yellow");
    v(G,0,0, 0,1,0, 1,0, "green");
    v(R,0,0, 1,0,20, 0,0, "new_onset_walk");

    // abort at countdown 12 with a press during WALK
    for (int k = 19; k >= 12; k--) v(R,k==15,0, 1,0,k, k<=15,0, "walk_press");
    v(G,0,0, 0,1,0, 1,0, "abort");
    v(G,0,0, 0,1,0, 1,0, "abort_idle");

    // pending request walks on next onset; reset mid-FLASH at countdown 5
    v(R,0,0, 1,0,20, 0,0, "rewalk");
    for (int k = 19; k >= 1; k--) v(R,0,0, 1,0,k, 0,0, "rewalk_count");
    for (int i = 0; i < 6; i++) v(R,0,0, 0,((i/2)%2)==0,10-i, 0,0, "flash_to5");
    v(R,0,1, 0,1,0, 0,0, "reset_mid_flash");
    v(R,0,0, 0,1,0, 0,0, "red_thru_release");
    v(R,1,0, 0,1,0, 1,0, "press_after_reset");
    v(R,0,0, 0,1,0, 1,0, "no_walk_no_onset");

    // fault from IDLE, sticky until reset
    v(3'b011,0,0, 0,1,0, 1,1, "fault_enter");
    v(G,1,0, 0,1,0, 1,1, "fault_sticky_g");
    v(R,1,0, 0,1,0, 1,1, "fault_sticky_r");
    v(Y,0,0, 0,1,0, 1,1, "fault_sticky_y");
    v(R,0,1, 0,1,0, 0,0, "fault_reset");

    // fault out of WALK takes priority over abort
    v(G,1,0, 0,1,0, 1,0, "press2");
    v(R,0,0, 1,0,20, 0,0, "walk3");
    v(3'b000,0,0, 0,1,0, 0,1, "fault_in_walk");
    v(R,0,1, 0,1,0, 0,0, "final_reset");

    started = 1'b1;
    foreach (vq[i]) begin
      light   = vq[i].light;
      ped_btn = vq[i].btn;
      reset   = vq[i].rst;
      @(posedge clk);
      #1;
      got = {walk, dont_walk, countdown, req_pending, fault};
      exp = {vq[i].w, vq[i].dw, vq[i].cd, vq[i].req, vq[i].flt};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL %s idx=%0d got w=%0b dw=%0b cd=%0d req=%0b flt=%0b required w=%0b dw=%0b cd=%0d req=%0b flt=%0b",
                 vq[i].tag, i, walk, dont_walk, countdown, req_pending, fault,
                 vq[i].w, vq[i].dw, vq[i].cd, vq[i].req, vq[i].flt);
      end
    end
    @(negedge clk);
    started = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
